// File: rtl/prog_clk_div_if.sv
// Configuration and output bundle for prog_clk_div; slave side is the divider.
// Adds clk_en when PROG_CLK_DIV_GATE_EN is defined.
interface prog_clk_div_if #(
    parameter int W = 4
);
    logic [W-1:0] cfg_n;
    logic [W:0]   cfg_h;
    logic         cfg_load;
    logic         cfg_pend;
    logic         cfg_ack;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;
`ifdef PROG_CLK_DIV_GATE_EN
    logic         clk_en;

    modport master (
        output cfg_n, cfg_h, cfg_load, clk_en,
        input  cfg_pend, cfg_ack, cfg_err, clk_out, tick
    );
    modport slave (
        input  cfg_n, cfg_h, cfg_load, clk_en,
        output cfg_pend, cfg_ack, cfg_err, clk_out, tick
    );
`else
    modport master (
        output cfg_n, cfg_h, cfg_load,
        input  cfg_pend, cfg_ack, cfg_err, clk_out, tick
    );
    modport slave (
        input  cfg_n, cfg_h, cfg_load,
        output cfg_pend, cfg_ack, cfg_err, clk_out, tick
    );
`endif
endinterface

// File: rtl/prog_clk_div.sv
// Integer clock divider: clk_out = clk/N, high for H half-periods; N/H reload only at period starts.
// Latency: rise one posedge after period start is sampled; cfg_ack/cfg_err/tick are 1-cycle registered pulses.
// No backpressure: loads always accepted or rejected. PROG_CLK_DIV_GATE_EN adds clk_en period suppression.
module prog_clk_div #(
    parameter int W     = 4,
    parameter int DEF_N = 5,
    parameter int DEF_H = 4
) (
    input  logic          clk,
    input  logic          rst,
    prog_clk_div_if.slave bus
);
    localparam logic [W-1:0] RST_N = W'(DEF_N);
    localparam logic [W:0]   RST_H = (W+1)'(DEF_H);

    logic [W-1:0] cnt, act_n, pend_n, nxt_cnt;
    logic [W:0]   act_h, pend_h, nxt_h;
    logic         pend, wrap, legal, en_q, nxt_en;
    logic         p_t, n_t, want_p, want_n;

    always_comb begin
        wrap    = (cnt == act_n - W'(1));
        nxt_cnt = wrap ? '0 : cnt + W'(1);
        nxt_h   = (wrap && pend) ? pend_h : act_h;
`ifdef PROG_CLK_DIV_GATE_EN
        nxt_en  = wrap ? bus.clk_en : en_q;
`else
        nxt_en  = 1'b1;
`endif
        legal   = (bus.cfg_n >= W'(2)) && (bus.cfg_h != '0) && (bus.cfg_h < {bus.cfg_n, 1'b0});
        // Desired output level for the half-period that follows each edge.
        want_p  = nxt_en && ({nxt_cnt, 1'b0} < nxt_h);
        want_n  = en_q && ({cnt, 1'b1} < act_h);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= RST_N - W'(1);
            act_n       <= RST_N;
            act_h       <= RST_H;
            pend        <= 1'b0;
            pend_n      <= '0;
            pend_h      <= '0;
            en_q        <= 1'b0;
            p_t         <= 1'b0;
            bus.tick    <= 1'b0;
            bus.cfg_ack <= 1'b0;
            bus.cfg_err <= 1'b0;
        end else begin
            cnt         <= nxt_cnt;
            en_q        <= nxt_en;
            p_t         <= want_p ^ n_t;
            bus.tick    <= wrap && nxt_en;
            bus.cfg_ack <= wrap && pend;
            bus.cfg_err <= bus.cfg_load && !legal;
            if (wrap && pend) begin
                act_n <= pend_n;
                act_h <= pend_h;
            end
            // A legal load on the apply edge re-arms pending with the new request.
            if (bus.cfg_load && legal) begin
                pend   <= 1'b1;
                pend_n <= bus.cfg_n;
                pend_h <= bus.cfg_h;
            end else if (wrap) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            n_t <= 1'b0;
        end else begin
            n_t <= want_n ^ p_t;
        end
    end

    // H=1 needs a rise and a fall on adjacent edges, so the two edge flops are
    // combined by XOR; only one input ever changes per edge, keeping it glitch-free.
    assign bus.clk_out  = p_t ^ n_t;
    assign bus.cfg_pend = pend;

endmodule
